// File: rtl/mem_ctrl.sv
// mem_ctrl: byte-serial RAM controller arbitrating mem-stage loads/stores over instruction fetches
//   clk_in, rst_in, rdy                     clock, async active-high reset, global ready
//   read_req_in, write_req_in, mem_addr_in,
//   mem_val_in, store_len_in                mem-stage request (read len = bytes, write len = bytes-1)
//   mem_done_out, mem_val_read_out          mem-stage completion pulse and load data
//   if_req_in, if_addr_in                   4-byte fetch request
//   if_done_out, inst_out                   fetch completion pulse and instruction
//   busy_out                                00 idle/done, 01 fetching, 10 serving mem
//   ram_din_in, io_buffer_full_in           RAM read byte (1-cycle latency), UART full
//   ram_a_out, ram_wr_out, ram_dout_out     RAM byte address, write enable, write byte
module mem_ctrl (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy,
    input  logic        read_req_in,
    input  logic        write_req_in,
    input  logic [31:0] mem_addr_in,
    input  logic [31:0] mem_val_in,
    input  logic [2:0]  store_len_in,
    output logic        mem_done_out,
    output logic [31:0] mem_val_read_out,
    output logic [1:0]  busy_out,
    input  logic        if_req_in,
    input  logic [31:0] if_addr_in,
    output logic        if_done_out,
    output logic [31:0] inst_out,
    input  logic [7:0]  ram_din_in,
    input  logic        io_buffer_full_in,
    output logic [31:0] ram_a_out,
    output logic        ram_wr_out,
    output logic [7:0]  ram_dout_out
);
    typedef enum logic [2:0] {IDLE, IF_RD, MEM_RD, MEM_WR, DONE} state_t;
    state_t state, state_nx;
    logic [2:0]  cnt, len;
    logic [1:0]  idx;
    logic [31:0] base, wdata, asm_q, asm_nx;
    logic        mem_req, stall, take_mem, take_if, fin;
    assign mem_req      = read_req_in | write_req_in;
    assign ram_a_out    = base + {29'b0, cnt};
    assign ram_dout_out = wdata[{cnt[1:0], 3'b000} +: 8];
    assign stall        = state == MEM_WR && ram_a_out[17:16] == 2'b11 && io_buffer_full_in;
    assign ram_wr_out   = state == MEM_WR && !stall;
    // the byte on ram_din_in belongs to the address issued one cycle earlier
    assign idx          = cnt[1:0] - 2'd1;
    always_comb begin
        asm_nx = asm_q;
        if (cnt != 3'd0) asm_nx[{idx, 3'b000} +: 8] = ram_din_in;
    end
    always_comb begin
        state_nx = state;
        take_mem = 1'b0;
        take_if  = 1'b0;
        fin      = 1'b0;
        case (state)
            IDLE:    begin
                take_mem = mem_req;
                take_if  = !mem_req && if_req_in;
            end
            // a mem request preempts an in-flight fetch; IF keeps requesting and is re-served
            IF_RD:   begin
                take_mem = mem_req;
                fin      = !mem_req && cnt == len;
            end
            MEM_RD:  fin = cnt == len;
            MEM_WR:  fin = !stall && cnt == len;
            default: state_nx = IDLE;
        endcase
        if (take_mem) state_nx = write_req_in ? MEM_WR : MEM_RD;
        else if (take_if) state_nx = IF_RD;
        else if (fin) state_nx = DONE;
    end
    always_ff @(posedge clk_in or posedge rst_in)
        if (rst_in) state <= IDLE;
        else if (rdy) state <= state_nx;
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            cnt              <= 3'd0;
            len              <= 3'd0;
            base             <= 32'd0;
            wdata            <= 32'd0;
            asm_q            <= 32'd0;
            mem_done_out     <= 1'b0;
            if_done_out      <= 1'b0;
            mem_val_read_out <= 32'd0;
            inst_out         <= 32'd0;
            busy_out         <= 2'b00;
        end else if (rdy) begin
            busy_out     <= state_nx == IF_RD ? 2'b01 :
                            (state_nx == MEM_RD || state_nx == MEM_WR) ? 2'b10 : 2'b00;
            mem_done_out <= fin && state != IF_RD;
            if_done_out  <= fin && state == IF_RD;
            if (take_mem || take_if) begin
                cnt   <= 3'd0;
                asm_q <= 32'd0;
                len   <= take_mem ? store_len_in : 3'd4;
                base  <= take_mem ? mem_addr_in : if_addr_in;
                wdata <= mem_val_in;
            end else if (state == IF_RD || state == MEM_RD) begin
                cnt   <= cnt + 3'd1;
                asm_q <= asm_nx;
            end else if (state == MEM_WR && !stall) begin
                cnt <= cnt + 3'd1;
            end
            if (fin && state == MEM_RD) mem_val_read_out <= asm_nx;
            if (fin && state == IF_RD) inst_out <= asm_nx;
        end
    end
endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: directed checks of mem_ctrl against a rdy-gated byte RAM model
module tb_mem_ctrl;
    logic        clk_in = 0, rst_in = 1, rdy = 1;
    logic        read_req_in = 0, write_req_in = 0, if_req_in = 0, io_buffer_full_in = 0;
    logic [31:0] mem_addr_in = 0, mem_val_in = 0, if_addr_in = 0;
    logic [2:0]  store_len_in = 0;
    logic        mem_done_out, if_done_out, ram_wr_out;
    logic [31:0] mem_val_read_out, inst_out, ram_a_out;
    logic [1:0]  busy_out;
    logic [7:0]  ram_din_in = 0, ram_dout_out;
    logic [7:0]  ram [0:262143];
    int          n_vec = 0, n_err = 0;

    mem_ctrl dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy(rdy),
        .read_req_in(read_req_in), .write_req_in(write_req_in),
        .mem_addr_in(mem_addr_in), .mem_val_in(mem_val_in), .store_len_in(store_len_in),
        .mem_done_out(mem_done_out), .mem_val_read_out(mem_val_read_out), .busy_out(busy_out),
        .if_req_in(if_req_in), .if_addr_in(if_addr_in), .if_done_out(if_done_out),
        .inst_out(inst_out), .ram_din_in(ram_din_in), .io_buffer_full_in(io_buffer_full_in),
        .ram_a_out(ram_a_out), .ram_wr_out(ram_wr_out), .ram_dout_out(ram_dout_out)
    );

    always #5 clk_in = ~clk_in;

    always @(posedge clk_in)
        if (rdy) begin
            if (ram_wr_out) ram[ram_a_out[17:0]] <= ram_dout_out;
            ram_din_in <= ram[ram_a_out[17:0]];
        end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic mem_rd(input logic [31:0] a, input logic [2:0] l);
        @(negedge clk_in);
        read_req_in = 1; mem_addr_in = a; store_len_in = l;
    endtask

    logic [7:0] sw_b [4] = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};

    initial begin
        int n;
        logic seen;
        ram[32'h100] = 8'h13; ram[32'h101] = 8'h05; ram[32'h102] = 8'h00; ram[32'h103] = 8'h00;
        ram[32'h40] = 8'h78;  ram[32'h41] = 8'h56;  ram[32'h42] = 8'h34;  ram[32'h43] = 8'h12;
        ram[32'h2001] = 8'h80;
        repeat (2) @(negedge clk_in);
        check("rst_busy", {30'd0, busy_out}, 0);
        check("rst_wr", {31'd0, ram_wr_out}, 0);
        check("rst_a", ram_a_out, 0);
        rst_in = 0;

        // fetch 0x100
        @(negedge clk_in);
        if_req_in = 1; if_addr_in = 32'h100;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk_in);
            if (c <= 4) check("if_addr", ram_a_out, 32'h100 + c - 1);
            check("if_busy", {30'd0, busy_out}, c <= 5 ? 1 : 0);
            check("if_done", {31'd0, if_done_out}, {31'd0, c == 6});
            if (c == 6) begin
                check("if_inst", inst_out, 32'h00000513);
                if_req_in = 0;
            end
        end

        // LB 0x2001
        mem_rd(32'h2001, 3'd1);
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk_in);
            check("lb_done", {31'd0, mem_done_out}, {31'd0, c == 3});
            if (c == 3) begin
                check("lb_val", mem_val_read_out, 32'h00000080);
                read_req_in = 0;
            end
        end

        // SW 0xDEADBEEF to 0x1000
        @(negedge clk_in);
        write_req_in = 1; mem_addr_in = 32'h1000; mem_val_in = 32'hDEADBEEF; store_len_in = 3'd3;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk_in);
            check("sw_wr", {31'd0, ram_wr_out}, {31'd0, c <= 4});
            check("sw_busy", {30'd0, busy_out}, c <= 4 ? 2 : 0);
            check("sw_done", {31'd0, mem_done_out}, {31'd0, c == 5});
            if (c <= 4) begin
                check("sw_addr", ram_a_out, 32'h1000 + c - 1);
                check("sw_byte", {24'd0, ram_dout_out}, {24'd0, sw_b[c-1]});
            end
            if (c == 5) write_req_in = 0;
        end
        check("sw_ram", {ram[32'h1003], ram[32'h1002], ram[32'h1001], ram[32'h1000]}, 32'hDEADBEEF);

        // fetch aborted by LW 0x40 in fetch cycle 2, then re-served
        @(negedge clk_in);
        if_req_in = 1; if_addr_in = 32'h100;
        @(negedge clk_in);
        check("ab_busy_if", {30'd0, busy_out}, 1);
        @(negedge clk_in);
        read_req_in = 1; mem_addr_in = 32'h40; store_len_in = 3'd4;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk_in);
            check("ab_no_ifdone", {31'd0, if_done_out}, 0);
            check("ab_lw_done", {31'd0, mem_done_out}, {31'd0, k == 6});
            if (k <= 4) check("ab_lw_addr", ram_a_out, 32'h40 + k - 1);
            if (k == 6) begin
                check("ab_lw_val", mem_val_read_out, 32'h12345678);
                read_req_in = 0;
            end
        end
        n = 0;
        while (!if_done_out && n < 12) begin
            @(negedge clk_in);
            n++;
        end
        check("ab_refetch_lat", n, 7);
        check("ab_refetch_inst", inst_out, 32'h00000513);
        if_req_in = 0;

        // SB to IO address stalled three cycles
        @(negedge clk_in);
        write_req_in = 1; mem_addr_in = 32'h30000; mem_val_in = 32'h000000A5; store_len_in = 3'd0;
        io_buffer_full_in = 1;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk_in);
            check("io_stall_wr", {31'd0, ram_wr_out}, 0);
            check("io_stall_done", {31'd0, mem_done_out}, 0);
        end
        @(posedge clk_in);
        #1 io_buffer_full_in = 0;
        @(negedge clk_in);
        check("io_wr", {31'd0, ram_wr_out}, 1);
        check("io_addr", ram_a_out, 32'h30000);
        check("io_byte", {24'd0, ram_dout_out}, 32'hA5);
        @(negedge clk_in);
        check("io_done", {31'd0, mem_done_out}, 1);
        check("io_ram", {24'd0, ram[18'h30000]}, 32'hA5);
        write_req_in = 0;

        // reset in cycle 2 of an LW
        mem_rd(32'h40, 3'd4);
        repeat (2) @(negedge clk_in);
        rst_in = 1; read_req_in = 0;
        #1;
        check("mid_rst_busy", {30'd0, busy_out}, 0);
        check("mid_rst_a", ram_a_out, 0);
        check("mid_rst_val", mem_val_read_out, 0);
        check("mid_rst_inst", inst_out, 0);
        @(negedge clk_in);
        rst_in = 0;
        seen = 0;
        repeat (8) begin
            @(negedge clk_in);
            seen |= mem_done_out | if_done_out;
        end
        check("mid_rst_no_done", {31'd0, seen}, 0);
        mem_rd(32'h40, 3'd4);
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk_in);
            check("post_rst_done", {31'd0, mem_done_out}, {31'd0, c == 6});
            if (c == 6) begin
                check("post_rst_val", mem_val_read_out, 32'h12345678);
                read_req_in = 0;
            end
        end

        // rdy low for two edges mid-LW
        mem_rd(32'h40, 3'd4);
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk_in);
            check("rdy_done", {31'd0, mem_done_out}, {31'd0, c == 8});
            if (c == 3) check("rdy_hold_busy", {30'd0, busy_out}, 2);
            if (c == 2) rdy = 0;
            if (c == 4) rdy = 1;
            if (c == 8) begin
                check("rdy_val", mem_val_read_out, 32'h12345678);
                read_req_in = 0;
            end
        end
        @(negedge clk_in);
        check("final_idle", {30'd0, busy_out}, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
